// File: rtl/wb_queue_stage.sv
// In-order writeback queue between MEM and the register file / CP0.
// Retires at most one instruction per cycle, flushes on exception/ERET at the head, and forwards the youngest pending write.
module wb_queue_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int WE_W   = 4,
  parameter int DEPTH  = 4,
  parameter int CP0A_W = 8,
  parameter int EXC_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ms_to_ws_valid,
  output logic                      ws_allowin,
  input  logic [31:0]               in_pc,
  input  logic [DATA_W-1:0]         in_result,
  input  logic [WE_W-1:0]           in_rf_we,
  input  logic [DEST_W-1:0]         in_dest,
  input  logic                      in_ex,
  input  logic [EXC_W-1:0]          in_excode,
  input  logic                      in_bd,
  input  logic                      in_eret,
  input  logic                      in_mtc0,
  input  logic                      in_mfc0,
  input  logic [CP0A_W-1:0]         in_cp0_addr,
  input  logic                      rf_hold,
  output logic [WE_W-1:0]           rf_we,
  output logic [DEST_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [CP0A_W-1:0]         cp0_raddr,
  input  logic [DATA_W-1:0]         cp0_rdata,
  output logic                      cp0_mtc0_we,
  output logic [DATA_W-1:0]         cp0_wdata,
  output logic                      ws_ex,
  output logic [EXC_W-1:0]          ws_excode,
  output logic                      ws_bd,
  output logic                      ws_eret,
  output logic [31:0]               ws_pc,
  input  logic [DEST_W-1:0]         fwd_raddr,
  output logic                      fwd_hit,
  output logic                      fwd_busy,
  output logic [DATA_W-1:0]         fwd_data,
  output logic [WE_W-1:0]           fwd_we,
  output logic [$clog2(DEPTH):0]    ws_count,
  output logic [31:0]               debug_wb_pc,
  output logic [3:0]                debug_wb_rf_wen,
  output logic [4:0]                debug_wb_rf_wnum,
  output logic [31:0]               debug_wb_rf_wdata
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [31:0]       pc;
    logic [DATA_W-1:0] result;
    logic [WE_W-1:0]   we;
    logic [DEST_W-1:0] dest;
    logic              ex;
    logic [EXC_W-1:0]  excode;
    logic              bd;
    logic              eret;
    logic              mtc0;
    logic              mfc0;
    logic [CP0A_W-1:0] cp0_addr;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head_e;
  logic [PW-1:0] head_ptr, tail_ptr;
  logic          full, head_v, retire, take_ex, take_eret, flush, wr_ok, enq;
  logic [IW-1:0] fwd_idx;

  // Handshake: an instruction moves from MEM into the queue on any clk edge where
  // ms_to_ws_valid && ws_allowin; ws_allowin depends only on registered occupancy.
  assign full       = (head_ptr[IW-1:0] == tail_ptr[IW-1:0]) && (head_ptr[IW] != tail_ptr[IW]);
  assign ws_allowin = !full;
  assign ws_count   = tail_ptr - head_ptr;
  assign head_v     = (head_ptr != tail_ptr);
  assign head_e     = mem[head_ptr[IW-1:0]];
  assign retire     = head_v && !rf_hold;
  assign take_ex    = retire && head_e.ex;
  assign take_eret  = retire && !head_e.ex && head_e.eret;
  assign flush      = take_ex || take_eret;
  assign wr_ok      = retire && !flush;
  assign enq        = ms_to_ws_valid && ws_allowin && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else if (flush) begin
      // Flush drops every queued entry and any same-cycle enqueue.
      head_ptr <= tail_ptr;
    end else begin
      if (retire) head_ptr <= head_ptr + PW'(1);
      if (enq)    tail_ptr <= tail_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail_ptr[IW-1:0]] <= '{pc: in_pc, result: in_result, we: in_rf_we, dest: in_dest,
                                 ex: in_ex, excode: in_excode, bd: in_bd, eret: in_eret,
                                 mtc0: in_mtc0, mfc0: in_mfc0, cp0_addr: in_cp0_addr};
    end
  end

  assign rf_we       = wr_ok ? head_e.we : '0;
  assign rf_waddr    = wr_ok ? head_e.dest : '0;
  assign rf_wdata    = wr_ok ? (head_e.mfc0 ? cp0_rdata : head_e.result) : '0;
  assign cp0_raddr   = head_v ? head_e.cp0_addr : '0;
  assign cp0_wdata   = head_v ? head_e.result : '0;
  assign cp0_mtc0_we = retire && head_e.mtc0 && !head_e.ex;
  assign ws_ex       = take_ex;
  assign ws_excode   = take_ex ? head_e.excode : '0;
  assign ws_bd       = take_ex && head_e.bd;
  assign ws_eret     = take_eret;
  assign ws_pc       = head_v ? head_e.pc : '0;

  assign debug_wb_pc       = retire ? head_e.pc : '0;
  assign debug_wb_rf_wen   = 4'(rf_we);
  assign debug_wb_rf_wnum  = 5'(rf_waddr);
  assign debug_wb_rf_wdata = 32'(rf_wdata);

  // Scan oldest to youngest so the last matching entry (closest to tail) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_busy = 1'b0;
    fwd_data = '0;
    fwd_we   = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_ptr[IW-1:0] + IW'(k);
      if ((PW'(k) < ws_count) && (mem[fwd_idx].we != '0) && !mem[fwd_idx].ex &&
          (mem[fwd_idx].dest == fwd_raddr) && (fwd_raddr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_we   = mem[fwd_idx].we;
        fwd_busy = mem[fwd_idx].mfc0 && (k != 0);
        fwd_data = (k == 0 && mem[fwd_idx].mfc0) ? cp0_rdata : mem[fwd_idx].result;
      end
    end
  end

endmodule

// File: tb/tb_wb_queue_stage.sv
// Testbench for wb_queue_stage: directed scenarios plus randomized traffic
// checked against a queue-based model of the writeback rules.
module tb_wb_queue_stage;

  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0, reset = 1'b0;
  logic        ms_to_ws_valid, ws_allowin;
  logic [31:0] in_pc, in_result;
  logic [3:0]  in_rf_we;
  logic [4:0]  in_dest, in_excode;
  logic        in_ex, in_bd, in_eret, in_mtc0, in_mfc0;
  logic [7:0]  in_cp0_addr;
  logic        rf_hold;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [7:0]  cp0_raddr;
  logic [31:0] cp0_rdata, cp0_wdata;
  logic        cp0_mtc0_we, ws_ex, ws_bd, ws_eret;
  logic [4:0]  ws_excode;
  logic [31:0] ws_pc;
  logic [4:0]  fwd_raddr;
  logic        fwd_hit, fwd_busy;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_we;
  logic [PW-1:0] ws_count;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic [3:0]  we;
    logic [4:0]  dest;
    logic        ex;
    logic [4:0]  excode;
    logic        bd, eret, mtc0, mfc0;
    logic [7:0]  addr;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  wb_queue_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .in_pc(in_pc), .in_result(in_result), .in_rf_we(in_rf_we), .in_dest(in_dest),
    .in_ex(in_ex), .in_excode(in_excode), .in_bd(in_bd), .in_eret(in_eret),
    .in_mtc0(in_mtc0), .in_mfc0(in_mfc0), .in_cp0_addr(in_cp0_addr), .rf_hold(rf_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cp0_raddr(cp0_raddr),
    .cp0_rdata(cp0_rdata), .cp0_mtc0_we(cp0_mtc0_we), .cp0_wdata(cp0_wdata),
    .ws_ex(ws_ex), .ws_excode(ws_excode), .ws_bd(ws_bd), .ws_eret(ws_eret), .ws_pc(ws_pc),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_busy(fwd_busy), .fwd_data(fwd_data),
    .fwd_we(fwd_we), .ws_count(ws_count), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  function automatic ent_t mk_alu(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res);
    ent_t e;
    e = '{pc: pc, result: res, we: 4'hf, dest: dest, ex: 1'b0, excode: 5'd0,
          bd: 1'b0, eret: 1'b0, mtc0: 1'b0, mfc0: 1'b0, addr: 8'd0};
    return e;
  endfunction

  task automatic drive(input logic v, input ent_t e);
    ms_to_ws_valid = v;
    in_pc = e.pc; in_result = e.result; in_rf_we = e.we; in_dest = e.dest;
    in_ex = e.ex; in_excode = e.excode; in_bd = e.bd; in_eret = e.eret;
    in_mtc0 = e.mtc0; in_mfc0 = e.mfc0; in_cp0_addr = e.addr;
  endtask

  task automatic idle();
    drive(1'b0, mk_alu(32'd0, 5'd0, 32'd0));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rf_hold = 1'b0; fwd_raddr = 5'd0; cp0_rdata = 32'd0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    fwd_raddr = 5'd3;
    #1;
    n_tests++; if (ws_count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", ws_count); end
    n_tests++; if (ws_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin got=%b exp=1", ws_allowin); end
    n_tests++; if ({rf_we, ws_ex, ws_eret, cp0_mtc0_we, fwd_hit} !== '0) begin n_fail++; $display("FAIL reset_strobes got=%b exp=0", {rf_we, ws_ex, ws_eret, cp0_mtc0_we, fwd_hit}); end
    n_tests++; if ({ws_pc, debug_wb_pc, cp0_raddr, cp0_wdata} !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", {ws_pc, debug_wb_pc, cp0_raddr, cp0_wdata}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, mk_alu(32'h100, 5'd3, 32'h11)); exp_q.push_back(32'h11);
    tick();
    drive(1'b1, mk_alu(32'h104, 5'd3, 32'h22)); exp_q.push_back(32'h22);
    #1;
    n_tests++; if (rf_we !== 4'hf || rf_waddr !== 5'd3) begin n_fail++; $display("FAIL b2b_first_we got=%h/%0d exp=f/3", rf_we, rf_waddr); end
    n_tests++; if (rf_wdata !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_first_data got=%h exp=11", rf_wdata); end
    n_tests++; if (debug_wb_pc !== 32'h100 || debug_wb_rf_wdata !== 32'h11) begin n_fail++; $display("FAIL b2b_debug got=%h/%h exp=100/11", debug_wb_pc, debug_wb_rf_wdata); end
    tick();
    idle();
    #1;
    n_tests++; if (rf_we !== 4'hf || rf_wdata !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_second got=%h/%h exp=f/22", rf_we, rf_wdata); end
    tick();
    #1;
    n_tests++; if (ws_count !== '0 || rf_we !== 4'h0) begin n_fail++; $display("FAIL b2b_drain got=%0d/%h exp=0/0", ws_count, rf_we); end
  endtask

  task automatic test_forwarding();
    do_reset();
    rf_hold = 1'b1;
    drive(1'b1, mk_alu(32'h200, 5'd3, 32'h11)); tick();
    drive(1'b1, mk_alu(32'h204, 5'd3, 32'h22)); tick();
    drive(1'b1, mk_alu(32'h208, 5'd0, 32'h44)); tick();
    idle();
    fwd_raddr = 5'd3; #1;
    n_tests++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22 || fwd_we !== 4'hf || fwd_busy !== 1'b0) begin n_fail++; $display("FAIL fwd_youngest got=%b/%h/%h/%b exp=1/22/f/0", fwd_hit, fwd_data, fwd_we, fwd_busy); end
    fwd_raddr = 5'd0; #1;
    n_tests++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_fail++; $display("FAIL fwd_r0 got=%b/%h exp=0/0", fwd_hit, fwd_data); end
    fwd_raddr = 5'd5; #1;
    n_tests++; if ({fwd_hit, fwd_busy, fwd_we, fwd_data} !== '0) begin n_fail++; $display("FAIL fwd_miss got=%h exp=0", {fwd_hit, fwd_busy, fwd_we, fwd_data}); end
  endtask

  task automatic test_full();
    do_reset();
    rf_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk_alu(32'h300 + 32'(4 * i), 5'(i + 1), 32'hA0 + 32'(i)));
      tick();
    end
    drive(1'b1, mk_alu(32'h3F0, 5'd9, 32'hFF));
    #1;
    n_tests++; if (ws_allowin !== 1'b0 || ws_count !== PW'(4)) begin n_fail++; $display("FAIL full_state got=%b/%0d exp=0/4", ws_allowin, ws_count); end
    tick();
    #1;
    n_tests++; if (ws_count !== PW'(4)) begin n_fail++; $display("FAIL full_fifth_dropped got=%0d exp=4", ws_count); end
    idle();
    rf_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (rf_we !== 4'hf || rf_waddr !== 5'(i + 1) || rf_wdata !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL full_drain%0d got=%h/%0d/%h exp=f/%0d/%h", i, rf_we, rf_waddr, rf_wdata, i + 1, 32'hA0 + 32'(i)); end
      n_tests++; if (ws_allowin !== (i != 0)) begin n_fail++; $display("FAIL full_allowin%0d got=%b exp=%b", i, ws_allowin, i != 0); end
      tick();
    end
    #1;
    n_tests++; if (ws_count !== '0 || rf_we !== 4'h0) begin n_fail++; $display("FAIL full_empty got=%0d/%h exp=0/0", ws_count, rf_we); end
  endtask

  task automatic test_exception();
    ent_t a;
    do_reset();
    rf_hold = 1'b1;
    a = mk_alu(32'hBFC00380, 5'd7, 32'h77);
    a.ex = 1'b1; a.excode = 5'h0C; a.bd = 1'b1;
    drive(1'b1, a); tick();
    drive(1'b1, mk_alu(32'h404, 5'd8, 32'h88)); tick();
    drive(1'b1, mk_alu(32'h408, 5'd9, 32'h99)); tick();
    idle(); #1;
    n_tests++; if (ws_ex !== 1'b0 || ws_count !== PW'(3)) begin n_fail++; $display("FAIL exc_held got=%b/%0d exp=0/3", ws_ex, ws_count); end
    tick();
    rf_hold = 1'b0;
    drive(1'b1, mk_alu(32'h40C, 5'd10, 32'hAA));
    #1;
    n_tests++; if (ws_ex !== 1'b1 || ws_excode !== 5'h0C || ws_bd !== 1'b1 || ws_eret !== 1'b0) begin n_fail++; $display("FAIL exc_pulse got=%b/%h/%b/%b exp=1/0c/1/0", ws_ex, ws_excode, ws_bd, ws_eret); end
    n_tests++; if (ws_pc !== 32'hBFC00380) begin n_fail++; $display("FAIL exc_pc got=%h exp=bfc00380", ws_pc); end
    n_tests++; if (rf_we !== 4'h0 || cp0_mtc0_we !== 1'b0) begin n_fail++; $display("FAIL exc_nowrite got=%h/%b exp=0/0", rf_we, cp0_mtc0_we); end
    tick();
    idle(); #1;
    n_tests++; if (ws_count !== '0 || ws_ex !== 1'b0 || rf_we !== 4'h0) begin n_fail++; $display("FAIL exc_flushed got=%0d/%b/%h exp=0/0/0", ws_count, ws_ex, rf_we); end
  endtask

  task automatic test_cp0();
    ent_t e;
    do_reset();
    cp0_rdata = 32'hCAFE0001;
    e = mk_alu(32'h500, 5'd0, 32'hDEADBEEF);
    e.we = 4'h0; e.mtc0 = 1'b1; e.addr = 8'h70;
    drive(1'b1, e); tick();
    idle(); #1;
    n_tests++; if (cp0_mtc0_we !== 1'b1 || cp0_raddr !== 8'h70 || cp0_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mtc0 got=%b/%h/%h exp=1/70/deadbeef", cp0_mtc0_we, cp0_raddr, cp0_wdata); end
    tick(); #1;
    n_tests++; if (cp0_mtc0_we !== 1'b0) begin n_fail++; $display("FAIL mtc0_once got=%b exp=0", cp0_mtc0_we); end
    rf_hold = 1'b1;
    drive(1'b1, mk_alu(32'h504, 5'd2, 32'h5)); tick();
    e = mk_alu(32'h508, 5'd9, 32'h0);
    e.mfc0 = 1'b1; e.addr = 8'h60;
    drive(1'b1, e); tick();
    idle();
    fwd_raddr = 5'd9; #1;
    n_tests++; if (fwd_hit !== 1'b1 || fwd_busy !== 1'b1 || fwd_we !== 4'hf) begin n_fail++; $display("FAIL mfc0_busy got=%b/%b/%h exp=1/1/f", fwd_hit, fwd_busy, fwd_we); end
    rf_hold = 1'b0; #1;
    n_tests++; if (rf_wdata !== 32'h5 || rf_waddr !== 5'd2) begin n_fail++; $display("FAIL mfc0_prev got=%h/%0d exp=5/2", rf_wdata, rf_waddr); end
    tick();
    rf_hold = 1'b1; #1;
    n_tests++; if (fwd_hit !== 1'b1 || fwd_busy !== 1'b0 || fwd_data !== 32'hCAFE0001) begin n_fail++; $display("FAIL mfc0_head_fwd got=%b/%b/%h exp=1/0/cafe0001", fwd_hit, fwd_busy, fwd_data); end
    rf_hold = 1'b0; #1;
    n_tests++; if (rf_wdata !== 32'hCAFE0001 || rf_waddr !== 5'd9 || rf_we !== 4'hf) begin n_fail++; $display("FAIL mfc0_retire got=%h/%0d/%h exp=cafe0001/9/f", rf_wdata, rf_waddr, rf_we); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk_alu(32'h600 + 32'(4 * i), 5'd4, 32'h60 + 32'(i)));
      tick();
    end
    idle();
    fwd_raddr = 5'd4;
    #1;
    n_tests++; if (ws_count !== PW'(3) || fwd_hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%0d/%b exp=3/1", ws_count, fwd_hit); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (ws_count !== '0 || ws_allowin !== 1'b1) begin n_fail++; $display("FAIL rstmid_async got=%0d/%b exp=0/1", ws_count, ws_allowin); end
    n_tests++; if ({fwd_hit, fwd_data, ws_pc, cp0_raddr, rf_we} !== '0) begin n_fail++; $display("FAIL rstmid_outputs got=%h exp=0", {fwd_hit, fwd_data, ws_pc, cp0_raddr, rf_we}); end
    @(negedge clk);
    reset = 1'b0;
    rf_hold = 1'b0;
    #1;
    n_tests++; if (ws_allowin !== 1'b1 || ws_count !== '0) begin n_fail++; $display("FAIL rstmid_after got=%b/%0d exp=1/0", ws_allowin, ws_count); end
  endtask

  // Randomized traffic against the model; dest is kept small so lookups hit often.
  task automatic test_random();
    ent_t e, h;
    int   sz, hit_i;
    logic v, hv, retire, e_ex, e_eret, e_wr, e_hit, e_busy;
    logic [3:0]  e_we, e_fwe;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_fdata;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v = ($urandom_range(0, 2) != 0);
      e.pc = $urandom; e.result = $urandom; e.dest = 5'($urandom_range(0, 3));
      e.we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
      e.ex = ($urandom_range(0, 15) == 0); e.excode = 5'($urandom); e.bd = 1'($urandom);
      e.eret = ($urandom_range(0, 15) == 0); e.mtc0 = ($urandom_range(0, 7) == 0);
      e.mfc0 = ($urandom_range(0, 3) == 0); e.addr = 8'($urandom);
      if (e.eret) begin e.we = 4'h0; e.mtc0 = 1'b0; e.mfc0 = 1'b0; end
      drive(v, e);
      rf_hold = ((c / 40) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      cp0_rdata = $urandom;
      fwd_raddr = 5'($urandom_range(0, 3));
      #1;
      sz = model_q.size();
      hv = (sz > 0);
      h = hv ? model_q[0] : mk_alu(32'd0, 5'd0, 32'd0);
      retire = hv && !rf_hold;
      e_ex   = retire && h.ex;
      e_eret = retire && !h.ex && h.eret;
      e_wr   = retire && !e_ex && !e_eret;
      e_we    = e_wr ? h.we : 4'h0;
      e_waddr = e_wr ? h.dest : 5'd0;
      e_wdata = e_wr ? (h.mfc0 ? cp0_rdata : h.result) : 32'd0;
      e_hit = 1'b0; e_busy = 1'b0; e_fwe = 4'h0; e_fdata = 32'd0; hit_i = -1;
      for (int i = sz - 1; i >= 0 && hit_i < 0; i--) begin
        if (model_q[i].we != 4'h0 && !model_q[i].ex && model_q[i].dest == fwd_raddr && fwd_raddr != 5'd0) hit_i = i;
      end
      if (hit_i >= 0) begin
        e_hit = 1'b1; e_fwe = model_q[hit_i].we;
        e_busy = model_q[hit_i].mfc0 && (hit_i != 0);
        e_fdata = (hit_i == 0 && model_q[hit_i].mfc0) ? cp0_rdata : model_q[hit_i].result;
      end
      n_tests++; if (ws_count !== PW'(sz) || ws_allowin !== (sz < DEPTH)) begin n_fail++; $display("FAIL rnd_occupancy cyc=%0d got=%0d/%b exp=%0d/%b", c, ws_count, ws_allowin, sz, sz < DEPTH); end
      n_tests++; if (rf_we !== e_we || rf_waddr !== e_waddr || rf_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_rf cyc=%0d got=%h/%0d/%h exp=%h/%0d/%h", c, rf_we, rf_waddr, rf_wdata, e_we, e_waddr, e_wdata); end
      n_tests++; if (debug_wb_rf_wen !== e_we || debug_wb_rf_wnum !== e_waddr || debug_wb_rf_wdata !== e_wdata || debug_wb_pc !== (retire ? h.pc : 32'd0)) begin n_fail++; $display("FAIL rnd_debug cyc=%0d got=%h/%0d/%h/%h", c, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_pc); end
      n_tests++; if (ws_ex !== e_ex || ws_eret !== e_eret || ws_excode !== (e_ex ? h.excode : 5'd0) || ws_bd !== (e_ex && h.bd)) begin n_fail++; $display("FAIL rnd_exc cyc=%0d got=%b/%b/%h/%b exp=%b/%b", c, ws_ex, ws_eret, ws_excode, ws_bd, e_ex, e_eret); end
      n_tests++; if (ws_pc !== (hv ? h.pc : 32'd0)) begin n_fail++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", c, ws_pc, hv ? h.pc : 32'd0); end
      n_tests++; if (cp0_mtc0_we !== (retire && h.mtc0 && !h.ex) || cp0_raddr !== (hv ? h.addr : 8'd0) || cp0_wdata !== (hv ? h.result : 32'd0)) begin n_fail++; $display("FAIL rnd_cp0 cyc=%0d got=%b/%h/%h", c, cp0_mtc0_we, cp0_raddr, cp0_wdata); end
      n_tests++; if (fwd_hit !== e_hit || fwd_busy !== e_busy || fwd_we !== e_fwe || fwd_data !== e_fdata) begin n_fail++; $display("FAIL rnd_fwd cyc=%0d got=%b/%b/%h/%h exp=%b/%b/%h/%h", c, fwd_hit, fwd_busy, fwd_we, fwd_data, e_hit, e_busy, e_fwe, e_fdata); end
      if (e_ex || e_eret) model_q.delete();
      else begin
        if (retire) void'(model_q.pop_front());
        if (v && sz < DEPTH) model_q.push_back(e);
      end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    rf_hold = 1'b0; fwd_raddr = 5'd0; cp0_rdata = 32'd0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_forwarding();
    test_full();
    test_exception();
    test_cp0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
